// File: rtl/modexp_seq.sv
// Sequential modular exponentiation: result = base^exp mod mod, right-to-left
// square-and-multiply over a bit-serial interleaved modular multiplier.
module modexp_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] base_i,
    input  logic [W-1:0] exp_i,
    input  logic [W-1:0] mod_i,
    output logic [W-1:0] result_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int AW = W + 2;
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RED,
        S_CHK,
        S_MUL,
        S_SQR,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   e_q, e_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   b_q, b_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           err_q, err_d;

    // Multiplier operand routing: X is consumed MSB first, Y must be < M
    // (RED uses Y = 1 so an unreduced base can sit on the X side).
    logic [W-1:0]   x_op, y_op;
    logic           x_bit;
    logic [AW-1:0]  m_ext, sum, t1, t2;

    always_comb begin
        x_op = a_q;
        y_op = W'(1);
        unique case (state_q)
            S_MUL: begin
                x_op = r_q;
                y_op = b_q;
            end
            S_SQR: begin
                x_op = b_q;
                y_op = b_q;
            end
            default: begin
                x_op = a_q;
                y_op = W'(1);
            end
        endcase
    end

    // acc_q < M < 2^W, so the shift cannot overflow AW bits; sum < 3M.
    always_comb begin
        x_bit = x_op[cnt_q];
        m_ext = {2'b00, m_q};
        sum   = (acc_q << 1) + (x_bit ? {2'b00, y_op} : '0);
        t1    = (sum >= m_ext) ? (sum - m_ext) : sum;
        t2    = (t1 >= m_ext) ? (t1 - m_ext) : t1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            e_q      <= e_d;
            m_q      <= m_d;
            r_q      <= r_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        e_d      = e_q;
        m_d      = m_q;
        r_d      = r_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d   = base_i;
                    e_d   = exp_i;
                    m_d   = mod_i;
                    b_d   = '0;
                    acc_d = '0;
                    cnt_d = CNT_MAX;
                    err_d = 1'b0;
                    if (mod_i == '0) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        r_d      = '0;
                        state_d  = S_DONE;
                    end else begin
                        r_d     = (mod_i == W'(1)) ? '0 : W'(1);
                        state_d = S_RED;
                    end
                end
            end
            S_RED, S_MUL, S_SQR: begin
                acc_d = t2;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    acc_d   = '0;
                    cnt_d   = CNT_MAX;
                    state_d = S_CHK;
                    if (state_q == S_MUL) begin
                        r_d = t2[W-1:0];
                        e_d = {e_q[W-1:1], 1'b0};
                    end else if (state_q == S_SQR) begin
                        b_d = t2[W-1:0];
                        e_d = e_q >> 1;
                    end else begin
                        b_d = t2[W-1:0];
                    end
                end
            end
            S_CHK: begin
                acc_d = '0;
                cnt_d = CNT_MAX;
                if (e_q == '0) begin
                    result_d = r_q;
                    state_d  = S_DONE;
                end else if (e_q[0]) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_SQR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q == S_RED) || (state_q == S_CHK) ||
                      (state_q == S_MUL) || (state_q == S_SQR);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign err_o    = err_q;

endmodule

// File: doc/modexp_seq.md
# modexp_seq

Sequential modular exponentiation engine computing result = base^exp mod mod using right-to-left square-and-multiply with a bit-serial interleaved modular multiplier. It sits directly upstream of the CRT recombination stage. Two instances produce m1 = c^dP mod p and m2 = c^dQ mod q. Unlike a direct `**` followed by `%`, it never forms the full power, so it is exact for any W-bit operands.

## Interface
- W, 32, operand/result width in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- base  input  W  base, any value; it is reduced mod `mod` internally.
- exp  input  W  exponent.
- mod  input  W  modulus; a value of 0 is an error.
- result  output  W  base^exp mod mod; held until the next accepted start.
- busy  output  1  high while in RED, CHK, MUL or SQR.
- done  output  1  one-cycle pulse when result is valid.
- err  output  1  set with done when mod == 0; cleared on the next accepted start.

## Operation
- Reset (async, rst_n = 0) forces:
  - state = IDLE;
  - result, busy, done, err = 0;
  - all internal registers = 0.
- **IDLE**: when start = 1, capture base→a, exp→e, mod→M.
  - If mod == 0: go to DONE with err = 1 and result = 0.
  - Otherwise: set r = (mod == 1) ? 0 : 1 and go to RED.
  - start in any other state is ignored.
- **RED** (W cycles): b = a·1 mod M on the multiplier, giving b < M.
- **CHK** (1 cycle):
  - e == 0 → DONE, with result ← r.
  - else if e[0] = 1 → MUL.
  - else → SQR.
- **MUL** (W cycles): r = r·b mod M, then e[0] ← 0, then go to CHK.
- **SQR** (W cycles): b = b·b mod M, then e ← e >> 1, then go to CHK.
- **DONE** (1 cycle): done = 1, then go to IDLE.
- Multiplier, computing X·Y mod M with Y < M:
  - Accumulator R is W+2 bits wide, starts at 0.
  - For i = W-1 down to 0, one bit per cycle: R ← 2R + (X[i] ? Y : 0), then conditionally subtract M up to twice so that R < M.
  - A 2-bit counter is not enough; use a log2(W)-bit bit counter.
- Width rules:
  - All intermediates are < M, except R before reduction, which is < 3M.
  - No truncation is permitted.
  - result < M always; result = 0 when M == 1.
- No early exit on b == 0 or b == 1; cycle count depends only on exp.

## Timing
- Count the edge that samples start as edge 0.
- Define k, the number of multiplies:
  - k = popcount(exp) + bitlen(exp) − 1 for exp > 0;
  - k = 0 for exp == 0.
- done is high in the cycle after edge (k+1)·(W+1) (W = 32 → 33·(k+1)).
- mod == 0: done and err are high in the cycle after edge 0.
- result updates on the same edge that asserts done, and stays stable afterwards.
- busy:
  - rises after edge 0;
  - falls on the edge that asserts done;
  - is never high together with done.
- A start held high through DONE is accepted again in IDLE, one cycle after done.
- Back-to-back operation: minimum spacing between accepted starts is (k+1)(W+1)+2 cycles.
- Reset asserted mid-operation aborts immediately:
  - no done pulse;
  - result reads 0;
  - the next start after release behaves as from power-up.

## Test plan
- base=4, exp=13, mod=497 → result=445, done after edge 231, busy high for exactly 231 cycles.
- RSA CRT vectors:
  - base=2790, exp=53, mod=61 → result=4 (exercises base ≥ mod);
  - base=2790, exp=49, mod=53 → result=12.
- Boundary cases:
  - exp=0, mod=7 → result=1 after edge 33;
  - exp=0, mod=1 → result=0;
  - base=0, exp=5, mod=11 → 0.
- Wide operands:
  - base=0xFFFFFFFF, exp=2, mod=0xFFFFFFFB → result=16;
  - base=0xFFFFFFFA, exp=0xFFFFFFFF, mod=0xFFFFFFFB → result=0xFFFFFFFA (−1 to an odd power); k=63, done after edge 2112.
- mod=0, any base and exp → err=1, done=1, result=0 one cycle after start. A following valid start clears err.
- Robustness:
  - Pulse rst_n low at edge 100 of the base=4/exp=13 run → outputs 0 immediately, no done pulse.
  - Restart the same run after release → 445.
  - A start pulsed while busy is ignored, and the result is unchanged.
